// File: rtl/gs_mem_cache_if.sv
// gs_mem_cache_if: upstream GS memory port plus downstream DDRAM bridge port of the GS byte cache
//   up_addr/up_din/up_rd/up_wr -> cache, up_dout/up_ready <- cache
//   dn_addr/dn_din/dn_rd/dn_we <- cache, dn_dout/dn_ready -> cache
//   slave modport is the cache view, master modport is the surrounding system (GS core + DDRAM bridge)
interface gs_mem_cache_if;
  logic [20:0] up_addr;
  logic [7:0]  up_din;
  logic        up_rd;
  logic        up_wr;
  logic [7:0]  up_dout;
  logic        up_ready;
  logic [20:0] dn_addr;
  logic [7:0]  dn_din;
  logic        dn_rd;
  logic        dn_we;
  logic [7:0]  dn_dout;
  logic        dn_ready;
  modport slave (
    input  up_addr, up_din, up_rd, up_wr, dn_dout, dn_ready,
    output up_dout, up_ready, dn_addr, dn_din, dn_rd, dn_we
  );
  modport master (
    output up_addr, up_din, up_rd, up_wr, dn_dout, dn_ready,
    input  up_dout, up_ready, dn_addr, dn_din, dn_rd, dn_we
  );
endinterface

// File: rtl/gs_mem_cache.sv
// gs_mem_cache: direct-mapped write-through byte cache between the GS memory port and the DDRAM bridge
//   clk_sys, reset_n (async, active low), gs_size (0=512KB 1=1MB 2/3=2MB window), cache_inv (invalidate pulse)
//   bus: gs_mem_cache_if.slave carrying the up_* GS port and the dn_* DDRAM port
//   GS_CACHE_STATS_EN: adds saturating stat_hits / stat_misses read counters
module gs_mem_cache #(
  parameter int LINES_LOG2 = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  gs_size,
  input  logic        cache_inv,
  gs_mem_cache_if.slave bus
`ifdef GS_CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int LINES = 1 << LINES_LOG2;
  localparam int TW = 21 - LINES_LOG2;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
  state_t state, state_d;
  logic [7:0]            data_mem [LINES];
  logic [TW-1:0]         tag_mem  [LINES];
  logic [LINES-1:0]      valid;
  logic                  req_q, inv_seen;
  logic [LINES_LOG2-1:0] idx, fidx;
  logic                  start, oow, hit, rd_start, wr_line, fill;
  logic                  ready_d, rd_d, we_d;
  logic [7:0]            dout_d, din_d;
  logic [20:0]           addr_d;
  assign idx      = bus.up_addr[LINES_LOG2-1:0];
  assign fidx     = bus.dn_addr[LINES_LOG2-1:0];
  assign start    = (bus.up_rd | bus.up_wr) & ~req_q;
  assign oow      = gs_size == 2'd0 ? |bus.up_addr[20:19] : gs_size == 2'd1 ? bus.up_addr[20] : 1'b0;
  // an invalidate arriving with the request forces a miss
  assign hit      = valid[idx] & (tag_mem[idx] == bus.up_addr[20:LINES_LOG2]) & ~cache_inv;
  assign rd_start = state == IDLE & start & ~bus.up_wr;
  assign wr_line  = state == IDLE & start & bus.up_wr & ~oow;
  // an invalidate at any point of the miss keeps the returned byte out of the cache
  assign fill     = state == RD_MISS & bus.dn_ready & ~inv_seen & ~cache_inv;
  always_comb begin
    state_d = state;
    ready_d = bus.up_ready;
    dout_d  = bus.up_dout;
    rd_d    = bus.dn_rd;
    we_d    = bus.dn_we;
    addr_d  = bus.dn_addr;
    din_d   = bus.dn_din;
    unique case (state)
      IDLE:
        if (wr_line) begin
          state_d = WR_THRU;
          ready_d = 1'b0;
          we_d    = 1'b1;
          din_d   = bus.up_din;
          addr_d  = bus.up_addr;
        end else if (rd_start & (oow | hit)) begin
          dout_d = oow ? 8'hFF : data_mem[idx];
        end else if (rd_start) begin
          state_d = RD_MISS;
          ready_d = 1'b0;
          rd_d    = 1'b1;
          addr_d  = bus.up_addr;
        end
      RD_MISS:
        if (bus.dn_ready) begin
          state_d = IDLE;
          dout_d  = bus.dn_dout;
          rd_d    = 1'b0;
          ready_d = 1'b1;
        end
      WR_THRU:
        if (bus.dn_ready) begin
          state_d = IDLE;
          we_d    = 1'b0;
          ready_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.up_ready <= 1'b1;
      bus.up_dout  <= 8'hFF;
      bus.dn_rd    <= 1'b0;
      bus.dn_we    <= 1'b0;
      bus.dn_addr  <= '0;
      bus.dn_din   <= '0;
      req_q        <= 1'b0;
      inv_seen     <= 1'b0;
      valid        <= '0;
    end else begin
      state        <= state_d;
      bus.up_ready <= ready_d;
      bus.up_dout  <= dout_d;
      bus.dn_rd    <= rd_d;
      bus.dn_we    <= we_d;
      bus.dn_addr  <= addr_d;
      bus.dn_din   <= din_d;
      req_q        <= bus.up_rd | bus.up_wr;
      inv_seen     <= state == IDLE ? 1'b0 : inv_seen | cache_inv;
      if (cache_inv) valid <= '0;
      else if (wr_line) valid[idx] <= 1'b1;
      else if (fill) valid[fidx] <= 1'b1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (wr_line) begin
      data_mem[idx] <= bus.up_din;
      tag_mem[idx]  <= bus.up_addr[20:LINES_LOG2];
    end else if (fill) begin
      data_mem[fidx] <= bus.dn_dout;
      tag_mem[fidx]  <= bus.dn_addr[20:LINES_LOG2];
    end
  end
`ifdef GS_CACHE_STATS_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (rd_start & (oow | hit) & ~&stat_hits) stat_hits <= stat_hits + 32'd1;
      if (rd_start & ~oow & ~hit & ~&stat_misses) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gs_mem_cache.sv
// tb_gs_mem_cache: randomized bench for gs_mem_cache against a line-level cache model and a DDRAM bridge model
module tb_gs_mem_cache;
  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] gs_size = 2'd2;
  logic       cache_inv = 1'b0;
  int         n_chk = 0, n_pass = 0;
  int         lat = 0, rd_cnt = 0, wr_cnt = 0, cnt = 0;
  logic [20:0] last_waddr;
  logic [7:0]  last_din;
  bit          ddr_wv [2097152];
  logic [7:0]  ddr_wd [2097152];
  bit          mv [256];
  logic [20:0] ma [256];
  logic [7:0]  md [256];
  logic [7:0]  ref_mem [int unsigned];
`ifdef GS_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif
  gs_mem_cache_if bus();
  gs_mem_cache dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .gs_size(gs_size), .cache_inv(cache_inv), .bus(bus)
`ifdef GS_CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );
  always #5 clk_sys = ~clk_sys;
  function automatic logic [7:0] base(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b0, a[20:16]} ^ 8'h78;
  endfunction
  function automatic logic [7:0] ddr_byte(input logic [20:0] a);
    return ddr_wv[a] ? ddr_wd[a] : base(a);
  endfunction
  function automatic logic [7:0] ref_byte(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : base(a);
  endfunction
  function automatic bit out_of_window(input logic [1:0] s, input logic [20:0] a);
    return (s == 2'd0 && a >= 21'h080000) || (s == 2'd1 && a >= 21'h100000);
  endfunction
  // DDRAM bridge: dn_ready pulses once, lat+1 cycles after the request is seen
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 0;
      bus.dn_ready <= 1'b0;
      bus.dn_dout <= 8'h00;
    end else if (bus.dn_ready) begin
      bus.dn_ready <= 1'b0;
      cnt <= 0;
      if (bus.dn_rd) rd_cnt <= rd_cnt + 1;
      if (bus.dn_we) begin
        wr_cnt <= wr_cnt + 1;
        ddr_wv[bus.dn_addr] <= 1'b1;
        ddr_wd[bus.dn_addr] <= bus.dn_din;
        last_waddr <= bus.dn_addr;
        last_din <= bus.dn_din;
      end
    end else if (bus.dn_rd || bus.dn_we) begin
      if (cnt == lat) begin
        bus.dn_ready <= 1'b1;
        bus.dn_dout <= bus.dn_rd ? ddr_byte(bus.dn_addr) : 8'h00;
      end
      cnt <= cnt + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic clear_model();
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
  endtask
  task automatic pulse_inv();
    @(negedge clk_sys) cache_inv = 1'b1;
    @(negedge clk_sys) cache_inv = 1'b0;
  endtask
  task automatic txn(input bit wr, input logic [20:0] a, input logic [7:0] d, input bit inv_mid);
    int i, rdc0, wrc0;
    bit oow, hit, busy_exp, busy;
    logic [7:0] exp;
    i = int'(a[7:0]);
    oow = out_of_window(gs_size, a);
    hit = !oow && mv[i] && ma[i] == a;
    busy_exp = !oow && (wr || !hit);
    exp = oow ? 8'hFF : hit ? md[i] : ref_byte(a);
    rdc0 = rd_cnt;
    wrc0 = wr_cnt;
    @(negedge clk_sys);
    bus.up_addr = a;
    bus.up_din = d;
    bus.up_rd = !wr;
    bus.up_wr = wr;
    @(posedge clk_sys) #1;
    busy = !bus.up_ready;
    check(wr ? "wr_busy" : "rd_busy", 32'(busy), 32'(busy_exp));
    if (inv_mid && busy) pulse_inv();
    for (int t = 0; t < 200 && !bus.up_ready; t++) begin
      @(posedge clk_sys) #1;
    end
    check("ready", 32'(bus.up_ready), 32'd1);
    bus.up_rd = 1'b0;
    bus.up_wr = 1'b0;
    if (!wr) check("rd_data", 32'(bus.up_dout), 32'(exp));
    check("dn_rd_cnt", 32'(rd_cnt - rdc0), 32'(!wr && busy_exp));
    check("dn_we_cnt", 32'(wr_cnt - wrc0), 32'(wr && busy_exp));
    if (wr && busy_exp) begin
      check("dn_din", 32'(last_din), 32'(d));
      check("dn_waddr", 32'(last_waddr), 32'(a));
      ref_mem[a] = d;
    end
    if (inv_mid && busy) clear_model();
    else if (busy_exp) begin
      mv[i] = 1'b1;
      ma[i] = a;
      md[i] = wr ? d : exp;
    end
    @(posedge clk_sys);
  endtask
  logic [12:0] hi_pool [5] = '{13'h0000, 13'h0001, 13'h0100, 13'h0800, 13'h1000};
  initial begin
    bus.up_addr = '0;
    bus.up_din = '0;
    bus.up_rd = 1'b0;
    bus.up_wr = 1'b0;
    clear_model();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys) #1;
    check("rst_ready", 32'(bus.up_ready), 32'd1);
    check("rst_dout", 32'(bus.up_dout), 32'hFF);
    check("rst_dn_rd", 32'(bus.dn_rd), 32'd0);
    check("rst_dn_we", 32'(bus.dn_we), 32'd0);
    check("rst_dn_addr", 32'(bus.dn_addr), 32'd0);
    check("rst_dn_din", 32'(bus.dn_din), 32'd0);
    lat = 6;
    txn(1'b0, 21'h00123, 8'h00, 1'b0);
    check("dir_5a", 32'(bus.up_dout), 32'h5A);
    txn(1'b0, 21'h00123, 8'h00, 1'b0);
    lat = 3;
    txn(1'b1, 21'h00200, 8'hC3, 1'b0);
    txn(1'b0, 21'h00200, 8'h00, 1'b0);
    check("dir_c3", 32'(bus.up_dout), 32'hC3);
    gs_size = 2'd0;
    txn(1'b0, 21'h080000, 8'h00, 1'b0);
    txn(1'b1, 21'h080000, 8'h11, 1'b0);
    gs_size = 2'd2;
    txn(1'b0, 21'h00010, 8'h00, 1'b0);
    txn(1'b0, 21'h10010, 8'h00, 1'b0);
    txn(1'b0, 21'h00010, 8'h00, 1'b0);
    lat = 5;
    txn(1'b0, 21'h00044, 8'h00, 1'b1);
    txn(1'b0, 21'h00044, 8'h00, 1'b0);
    lat = 20;
    @(negedge clk_sys);
    bus.up_addr = 21'h00300;
    bus.up_rd = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 check("mid_dn_rd", 32'(bus.dn_rd), 32'd1);
    @(negedge clk_sys) reset_n = 1'b0;
    #1;
    check("abort_dn_rd", 32'(bus.dn_rd), 32'd0);
    check("abort_ready", 32'(bus.up_ready), 32'd1);
    check("abort_dout", 32'(bus.up_dout), 32'hFF);
    bus.up_rd = 1'b0;
    clear_model();
    @(negedge clk_sys) reset_n = 1'b1;
    lat = 2;
    txn(1'b0, 21'h00123, 8'h00, 1'b0);
    txn(1'b0, 21'h00200, 8'h00, 1'b0);
    for (int n = 0; n < 300; n++) begin
      logic [20:0] a;
      bit inv;
      a = {hi_pool[$urandom_range(0, 4)], 8'($urandom_range(0, 7))};
      gs_size = $urandom_range(0, 3) == 0 ? 2'($urandom_range(0, 1)) : 2'd2;
      inv = $urandom_range(0, 9) == 0;
      lat = inv ? $urandom_range(1, 6) : $urandom_range(0, 6);
      if ($urandom_range(0, 15) == 0) begin
        pulse_inv();
        clear_model();
      end
      txn($urandom_range(0, 2) == 0, a, 8'($urandom), inv);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
